multiplier_seq: RTL and testbench

Parametrised sequential shift-add multiplier for the CPU's multiply unit, successor to the fixed 32-bit MULT-only block. It supports signed (MULT) and unsigned (MULTU) operation at any operand width, uses an explicit start/busy/done handshake instead of free-running on every clock, and holds the full 2*WIDTH-bit product stable until the next operation completes. It sits beside the ALU in the execute stage and feeds the HI/LO registers.

---
 rtl/multiplier_seq.sv | 85 ++++++++
 tb/tb_multiplier_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier: signed/unsigned WIDTH x WIDTH -> 2*WIDTH product,
// one partial product per cycle, start/busy/done handshake.
module multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] acc_next;

    // Most-negative input negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
    always_comb begin
        abs_a = (is_signed && dataA[WIDTH-1]) ? (~dataA + 1'b1) : dataA;
        abs_b = (is_signed && dataB[WIDTH-1]) ? (~dataB + 1'b1) : dataB;
    end

    always_comb begin
        acc_next = acc;
        if (mag_b[0])
            acc_next = acc + mag_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dataOut <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= {{WIDTH{1'b0}}, abs_a};
                        mag_b <= abs_b;
                        neg   <= is_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    mag_a <= mag_a << 1;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    dataOut <= neg ? (~acc + 1'b1) : acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplier_seq.sv
// Directed bench for multiplier_seq: WIDTH=32 instance for the main plan, WIDTH=8 for the narrow case.
module tb_multiplier_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_signed;
    logic [31:0] dataA, dataB;
    logic        busy, done;
    logic [63:0] dataOut;

    logic        start8, is_signed8;
    logic [7:0]  dataA8, dataB8;
    logic        busy8, done8;
    logic [15:0] dataOut8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multiplier_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done), .dataOut(dataOut)
    );

    multiplier_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(is_signed8),
        .dataA(dataA8), .dataB(dataB8), .busy(busy8), .done(done8), .dataOut(dataOut8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next posedge (edge T).
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        dataA = a; dataB = b; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts edges after T; returns at the negedge where done is seen.
    // p1/p2: lat values at which a stray start pulse (operands 3,3) is injected.
    task automatic wait_done(input int p1, input int p2, input logic [63:0] hold, input bit do_hold,
                             output int lat, output int bcnt, output bit hold_ok);
        lat = 0; bcnt = 0; hold_ok = 1'b1;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (do_hold && dataOut !== hold) hold_ok = 1'b0;
            if (lat == p1 || lat == p2) begin
                start = 1'b1; dataA = 32'd3; dataB = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (lat >= 100) chk("done_timeout", 64'(lat), 64'd33);
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp);
        int lat, bc; bit hok;
        launch(a, b, s);
        wait_done(-1, -1, '0, 1'b0, lat, bc, hok);
        chk({tag, "_lat"}, 64'(lat), 64'd33);
        chk({tag, "_prod"}, dataOut, exp);
    endtask

    initial begin
        int lat, bc, dcnt;
        bit hok;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dataA = '0; dataB = '0;
        start8 = 1'b0; is_signed8 = 1'b0; dataA8 = '0; dataB8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out", dataOut, 64'd0);
        chk("rst_out8", 64'(dataOut8), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Unsigned max x max, with latency and busy duration
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(-1, -1, '0, 1'b0, lat, bc, hok);
        chk("umax_lat", 64'(lat), 64'd33);
        chk("umax_busy_cycles", 64'(bc), 64'd33);
        chk("umax_busy_at_done", 64'(busy), 64'd0);
        chk("umax_prod", dataOut, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);

        run32("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        run32("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run32("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
        @(negedge clk);

        // Zero operand; stray starts while busy must be ignored; prior product held
        launch(32'd0, 32'h1234_5678, 1'b1);
        wait_done(5, 20, 64'hFFFF_FFFF_8000_0000, 1'b1, lat, bc, hok);
        chk("zero_lat", 64'(lat), 64'd33);
        chk("zero_hold_prev", 64'(hok), 64'd1);
        chk("zero_prod", dataOut, 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("zero_single_done", 64'(dcnt), 64'd0);
        chk("idle_hold", dataOut, 64'd0);

        // Back-to-back: second start issued in the done cycle of the first
        launch(32'd9, 32'd11, 1'b0);
        wait_done(-1, -1, '0, 1'b0, lat, bc, hok);
        chk("b2b_first", dataOut, 64'd99);
        launch(32'd6, 32'd7, 1'b0);
        chk("b2b_accepted", 64'(busy), 64'd1);
        wait_done(-1, -1, 64'd99, 1'b1, lat, bc, hok);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_hold", 64'(hok), 64'd1);
        chk("b2b_prod", dataOut, 64'd42);
        @(negedge clk);

        // Reset mid-operation
        launch(32'd5, 32'd5, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_out", dataOut, 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", 64'(dcnt), 64'd0);
        run32("after_rst", 32'd5, 32'd5, 1'b0, 64'd25);
        @(negedge clk);

        // reset and start together: reset wins
        reset = 1'b1; start = 1'b1; dataA = 32'd2; dataB = 32'd2;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst_vs_start_busy", 64'(busy), 64'd0);
        chk("rst_vs_start_out", dataOut, 64'd0);
        @(negedge clk);

        // WIDTH=8 signed: -128 x -1
        dataA8 = 8'h80; dataB8 = 8'hFF; is_signed8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_lat", 64'(lat), 64'd9);
        chk("w8_prod", 64'(dataOut8), 64'h0080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
